// File: rtl/rr_mux_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter_4
// Purpose  : Round-robin arbiter sharing one 4:1 data mux between four
//            valid/ready requesters, feeding a single registered output
//            channel. A packet, delimited by in_last, is kept contiguous by
//            locking the grant to its owner until its last beat is accepted.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            in_valid[3:0]      - requester i offers a beat
//            in_last[3:0]       - offered beat of requester i ends its packet
//            in_data[4*W-1:0]   - requester i data in bits [i*W +: W]
//            in_ready[3:0]      - one-hot acceptance strobe (combinational)
//            out_valid/out_ready- registered output handshake
//            out_data/out_id/out_last - accepted beat, source index, last flag
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter_4 #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     in_valid,
  input  logic [3:0]     in_last,
  input  logic [4*W-1:0] in_data,
  output logic [3:0]     in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_id,
  output logic           out_last
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     owner_q, owner_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [1:0]     out_id_q, out_id_d;
  logic           out_last_q, out_last_d;

  logic [1:0]     sel;
  logic           load;

  // Grant selection. In IDLE the scan runs from ptr+3 down to ptr so that the
  // last assignment wins, giving priority ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // When nothing is valid sel stays at ptr, whose in_valid is 0, so no load.
  always_comb begin
    sel = ptr_q;
    if (state_q == LOCK) begin
      sel = owner_q;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (in_valid[ptr_q + 2'(k)]) begin
          sel = ptr_q + 2'(k);
        end
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  // rst gates the strobe so in_ready is quiet for the whole reset window.
  assign load     = !rst && (!out_valid_q || out_ready) && in_valid[sel];
  assign in_ready = load ? (4'b0001 << sel) : 4'b0000;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[sel*W +: W];
      out_id_d    = sel;
      out_last_d  = in_last[sel];
      if (in_last[sel]) begin
        // Packet complete: rotate priority past the requester just served.
        ptr_d   = sel + 2'd1;
        state_d = IDLE;
      end else begin
        state_d = LOCK;
        owner_d = sel;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      owner_q     <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= 2'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arbiter_4
// Purpose  : Directed self-checking bench for rr_mux_arbiter_4 (W=4).
//            Inputs change 1 time unit after a rising edge; in_ready is
//            checked 1 unit later, registered outputs right after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter_4;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     in_valid;
  logic [3:0]     in_last;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;
  logic           out_last;

  int tests  = 0;
  int failed = 0;

  rr_mux_arbiter_4 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] id,
                           input logic [W-1:0] d, input logic l);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_id"},    32'(out_id),    32'(id));
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_last"},  32'(out_last),  32'(l));
  endtask

  initial begin
    // ---------------- reset then idle ----------------
    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    in_data   = '0;
    out_ready = 1'b1;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check_out("rst", 1'b0, 2'd0, 4'h0, 1'b0);
    step();
    rst      = 1'b0;
    in_valid = 4'b0000;
    step();
    check_out("idle", 1'b0, 2'd0, 4'h0, 1'b0);
    check("idle_in_ready", 32'(in_ready), 32'h0);

    // ---------------- fairness: 0,1,2,3,0 ----------------
    for (int i = 0; i < 4; i++) set_data(i, 4'(i + 1));
    in_last  = 4'b1111;
    in_valid = 4'b1111;
    settle();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fair_in_ready%0d", i), 32'(in_ready), 32'(4'b0001 << (i % 4)));
      step();
      check_out($sformatf("fair%0d", i), 1'b1, 2'(i % 4), 4'((i % 4) + 1), 1'b1);
    end
    // ptr is now 1
    in_valid = 4'b0000;
    step();
    check("fair_drain", 32'(out_valid), 32'h0);

    // ---------------- pointer wrap and skip ----------------
    in_valid = 4'b0100;   // grant 2 -> ptr 3
    settle();
    check("wrap_in_ready_r2", 32'(in_ready), 32'h4);
    step();
    check_out("wrap_r2", 1'b1, 2'd2, 4'h3, 1'b1);
    in_valid = 4'b0011;   // scan 3,0 -> requester 0
    settle();
    check("wrap_in_ready_r0", 32'(in_ready), 32'h1);
    step();
    check_out("wrap_r0", 1'b1, 2'd0, 4'h1, 1'b1);
    in_valid = 4'b0010;   // requester 0 accepted and dropped
    settle();
    check("wrap_in_ready_r1", 32'(in_ready), 32'h2);
    step();
    check_out("wrap_r1", 1'b1, 2'd1, 4'h2, 1'b1);
    // ptr is now 2; send one beat from requester 0 to move ptr to 1
    in_valid = 4'b0001;
    step();
    check_out("pre_lock_r0", 1'b1, 2'd0, 4'h1, 1'b1);

    // ---------------- packet lock with bubble ----------------
    set_data(1, 4'h1);
    set_data(2, 4'hC);
    in_last  = 4'b0100;   // requester 1 beat not last, requester 2 single beat
    in_valid = 4'b0110;
    settle();
    check("lock_b1_in_ready", 32'(in_ready), 32'h2);
    step();
    check_out("lock_b1", 1'b1, 2'd1, 4'h1, 1'b0);
    in_valid = 4'b0100;   // bubble from owner, requester 2 still waiting
    settle();
    check("lock_bub1_in_ready", 32'(in_ready), 32'h0);
    step();
    check("lock_bub1_drain", 32'(out_valid), 32'h0);
    check("lock_bub2_in_ready", 32'(in_ready), 32'h0);
    step();
    set_data(1, 4'h2);
    in_valid = 4'b0110;
    settle();
    check("lock_b2_in_ready", 32'(in_ready), 32'h2);
    step();
    check_out("lock_b2", 1'b1, 2'd1, 4'h2, 1'b0);
    set_data(1, 4'h3);
    in_last = 4'b0110;
    settle();
    check("lock_b3_in_ready", 32'(in_ready), 32'h2);
    step();
    check_out("lock_b3", 1'b1, 2'd1, 4'h3, 1'b1);
    in_valid = 4'b0100;
    settle();
    check("lock_r2_in_ready", 32'(in_ready), 32'h4);
    step();
    check_out("lock_r2", 1'b1, 2'd2, 4'hC, 1'b1);
    // ptr is now 3
    in_valid = 4'b0000;
    step();
    check("lock_drain", 32'(out_valid), 32'h0);

    // ---------------- backpressure ----------------
    set_data(0, 4'hA);
    in_last   = 4'b1111;
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    step();
    check_out("bp_load", 1'b1, 2'd0, 4'hA, 1'b1);
    set_data(3, 4'h5);
    in_valid = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'h0);
      step();
      check_out($sformatf("bp_hold%0d", i), 1'b1, 2'd0, 4'hA, 1'b1);
    end
    out_ready = 1'b1;
    settle();
    check("bp_release_in_ready", 32'(in_ready), 32'h8);
    step();
    check_out("bp_swap", 1'b1, 2'd3, 4'h5, 1'b1);
    // ptr is now 0
    in_valid = 4'b0000;
    step();
    check("bp_drain", 32'(out_valid), 32'h0);

    // ---------------- async reset mid-packet ----------------
    set_data(0, 4'h1);
    in_last  = 4'b0000;
    in_valid = 4'b0001;
    step();
    check_out("ar_b1", 1'b1, 2'd0, 4'h1, 1'b0);
    set_data(0, 4'h2);
    settle();
    rst = 1'b1;
    #1;
    check("ar_out_valid_now", 32'(out_valid), 32'h0);
    check("ar_in_ready_now", 32'(in_ready), 32'h0);
    step();
    rst = 1'b0;
    set_data(2, 4'h9);
    in_last  = 4'b0100;
    in_valid = 4'b0100;
    settle();
    check("ar_r2_in_ready", 32'(in_ready), 32'h4);
    step();
    check_out("ar_r2", 1'b1, 2'd2, 4'h9, 1'b1);
    // ptr is now 3: requesters 1 and 3 valid -> 3 wins
    set_data(1, 4'h6);
    set_data(3, 4'h7);
    in_last  = 4'b1111;
    in_valid = 4'b1010;
    settle();
    check("ar_ptr_in_ready", 32'(in_ready), 32'h8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 20000", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
